// File: rtl/root_data_return_net_pkg.sv
// Shared constants and twiddle block type for the NTT/INTT <-> root-power interconnect.
package root_data_return_net_pkg;

    localparam int FSIZE          = 16;  // coefficient width
    localparam int logE           = 2;   // butterfly stages per NTT unit
    localparam int E              = 4;   // lanes; E/2 twiddles per stage
    localparam int N              = 16;  // polynomial length
    localparam int NTT_INTT_NUM   = 4;   // NTT/INTT units
    localparam int ROOT_POWER_NUM = 4;   // root-power RAM banks

    // One bank read beat: a twiddle for every butterfly of every stage.
    typedef logic [logE-1:0][E/2-1:0][FSIZE-1:0] twiddle_blk_t;

endpackage

// File: rtl/root_data_return_net_sel_pipe.sv
// Select delay line: carries {valid, select} from request issue until the
// root-power RAM read data for that request is present at the mux tree input.
// The valid bit is the MSB; a valid clear drops every beat already in the line
// while the entry being written this cycle is still accepted.
module rdn_sel_pipe
    import root_data_return_net_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per cycle; valid_clr kills in-flight beats but not the new one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= {stage[i-1][WIDTH-1] & ~valid_clr, stage[i-1][WIDTH-2:0]};
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/root_data_return_net.sv
// Return path of the root-power interconnect: routes W/WQ twiddle read data
// from ROOT_NUM banks to NTT_NUM units. Each request's bank select is delayed
// to line up with the RAM read data, then the beat walks a registered binary
// mux tree, one select bit per level (LSB first). Outputs are zero when idle.
module root_data_return_net
    import root_data_return_net_pkg::*;
#(
    parameter int  NTT_NUM   = NTT_INTT_NUM,
    parameter int  ROOT_NUM  = ROOT_POWER_NUM,
    parameter int  SEL_DELAY = 3,
    localparam int LVL       = $clog2(ROOT_NUM)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [NTT_NUM-1:0]                req_valid,
    input  logic [NTT_NUM-1:0][LVL-1:0]       root_select,
    input  twiddle_blk_t [ROOT_NUM-1:0]       root_rdata_W,
    input  twiddle_blk_t [ROOT_NUM-1:0]       root_rdata_WQ,
    output twiddle_blk_t [NTT_NUM-1:0]        ntt_rdata_W,
    output twiddle_blk_t [NTT_NUM-1:0]        ntt_rdata_WQ,
    output logic [NTT_NUM-1:0]                ntt_rdata_valid
);

    if (ROOT_NUM < 2 || (ROOT_NUM & (ROOT_NUM - 1)) != 0) begin : g_bad_root_num
        $error("root_data_return_net: ROOT_NUM must be a power of two >= 2");
    end
    if (SEL_DELAY < 1) begin : g_bad_sel_delay
        $error("root_data_return_net: SEL_DELAY must be >= 1");
    end

    for (genvar n = 0; n < NTT_NUM; n++) begin : g_ntt
        // {valid, select} at the moment this NTT's bank data reaches the tree
        logic [LVL:0] tail;

        rdn_sel_pipe #(
            .WIDTH (LVL + 1),
            .DEPTH (SEL_DELAY)
        ) u_sel_pipe (
            .clk       (clk),
            .rst       (rst),
            .valid_clr (flush),
            .din       ({req_valid[n], root_select[n]}),
            .dout      (tail)
        );

        for (genvar k = 0; k < LVL; k++) begin : g_lvl
            localparam int NODES = ROOT_NUM >> (k + 1);

            logic         sel_bit;
            logic         vld_in;
            logic         vld_q;
            twiddle_blk_t cand_w  [2*NODES];
            twiddle_blk_t cand_wq [2*NODES];
            twiddle_blk_t w_q     [NODES];
            twiddle_blk_t wq_q    [NODES];

            if (k == 0) begin : g_src_banks
                assign sel_bit = tail[0];
                assign vld_in  = tail[LVL];
                for (genvar j = 0; j < 2*NODES; j++) begin : g_cand
                    assign cand_w[j]  = root_rdata_W[j];
                    assign cand_wq[j] = root_rdata_WQ[j];
                end
            end else begin : g_src_prev
                assign sel_bit = g_lvl[k-1].g_sel.sel_q[0];
                assign vld_in  = g_lvl[k-1].vld_q;
                for (genvar j = 0; j < 2*NODES; j++) begin : g_cand
                    assign cand_w[j]  = g_lvl[k-1].w_q[j];
                    assign cand_wq[j] = g_lvl[k-1].wq_q[j];
                end
            end

            // Select bits still needed by deeper levels travel with the beat.
            if (k < LVL - 1) begin : g_sel
                logic [LVL-2-k:0] sel_q;
                logic [LVL-2-k:0] sel_nxt;

                if (k == 0) begin : g_first
                    assign sel_nxt = tail[LVL-1:1];
                end else begin : g_rest
                    assign sel_nxt = g_lvl[k-1].g_sel.sel_q[LVL-1-k:1];
                end

                // Register the remaining select bits alongside this level's data.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        sel_q <= '0;
                    end else begin
                        sel_q <= sel_nxt;
                    end
                end
            end

            // Registered 2:1 mux per pair; flush drops the beat's valid.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    for (int j = 0; j < NODES; j++) begin
                        w_q[j]  <= '0;
                        wq_q[j] <= '0;
                    end
                end else begin
                    vld_q <= vld_in & ~flush;
                    for (int j = 0; j < NODES; j++) begin
                        w_q[j]  <= sel_bit ? cand_w[2*j+1]  : cand_w[2*j];
                        wq_q[j] <= sel_bit ? cand_wq[2*j+1] : cand_wq[2*j];
                    end
                end
            end
        end

        // Idle bus is held at zero so downstream never sees stale twiddles.
        assign ntt_rdata_valid[n] = g_lvl[LVL-1].vld_q;
        assign ntt_rdata_W[n]     = g_lvl[LVL-1].vld_q ? g_lvl[LVL-1].w_q[0]  : '0;
        assign ntt_rdata_WQ[n]    = g_lvl[LVL-1].vld_q ? g_lvl[LVL-1].wq_q[0] : '0;
    end

endmodule

// File: tb/tb_root_data_return_net.sv
// Self-checking bench for root_data_return_net. Expected outputs come from a
// cycle-indexed history of requests/bank data: a request at cycle t is seen at
// t+5 carrying bank data from t+3 unless a reset or flush intervened.
module tb_root_data_return_net;
    import root_data_return_net_pkg::*;

    localparam int NN   = 4;
    localparam int RN   = 4;
    localparam int LV   = 2;
    localparam int LAT  = 5;
    localparam int DDLY = 3;
    localparam int MAXC = 1024;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic [NN-1:0]            req_valid;
    logic [NN-1:0][LV-1:0]    root_select;
    twiddle_blk_t [RN-1:0]    root_rdata_W;
    twiddle_blk_t [RN-1:0]    root_rdata_WQ;
    twiddle_blk_t [NN-1:0]    ntt_rdata_W;
    twiddle_blk_t [NN-1:0]    ntt_rdata_WQ;
    logic [NN-1:0]            ntt_rdata_valid;

    root_data_return_net #(
        .NTT_NUM   (NN),
        .ROOT_NUM  (RN),
        .SEL_DELAY (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .req_valid       (req_valid),
        .root_select     (root_select),
        .root_rdata_W    (root_rdata_W),
        .root_rdata_WQ   (root_rdata_WQ),
        .ntt_rdata_W     (ntt_rdata_W),
        .ntt_rdata_WQ    (ntt_rdata_WQ),
        .ntt_rdata_valid (ntt_rdata_valid)
    );

    always #5 clk = ~clk;

    // staged stimulus for the next cycle
    logic                  s_rst, s_flush;
    logic [NN-1:0]         s_req;
    logic [NN-1:0][LV-1:0] s_sel;
    twiddle_blk_t [RN-1:0] s_w, s_wq;

    // history
    bit           h_req [MAXC][NN];
    bit [LV-1:0]  h_sel [MAXC][NN];
    bit           h_rst [MAXC];
    bit           h_fl  [MAXC];
    twiddle_blk_t h_w   [MAXC][RN];
    twiddle_blk_t h_wq  [MAXC][RN];

    int cyc     = -1;
    int n_checks = 0;
    int n_fail   = 0;

    function automatic bit exp_valid(int c, int n);
        int t = c - LAT;
        if (t < 0) return 1'b0;
        if (!h_req[t][n]) return 1'b0;
        for (int i = t; i <= c; i++) if (h_rst[i]) return 1'b0;
        for (int i = t + 1; i < t + LAT; i++) if (h_fl[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic twiddle_blk_t exp_data(int c, int n, bit wq);
        int t = c - LAT;
        int b;
        if (!exp_valid(c, n)) return '0;
        b = int'(h_sel[t][n]);
        return wq ? h_wq[t+DDLY][b] : h_w[t+DDLY][b];
    endfunction

    task automatic rand_banks();
        for (int b = 0; b < RN; b++) begin
            s_w[b]  = {$urandom, $urandom};
            s_wq[b] = {$urandom, $urandom};
        end
    endtask

    task automatic idle_stim();
        s_rst   = 1'b0;
        s_flush = 1'b0;
        s_req   = '0;
        s_sel   = 8'($urandom);
        rand_banks();
    endtask

    // advance one cycle: apply staged inputs after the edge, record, go to negedge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1);
        end
        rst = s_rst; flush = s_flush; req_valid = s_req; root_select = s_sel;
        root_rdata_W = s_w; root_rdata_WQ = s_wq;
        h_rst[cyc] = s_rst;
        h_fl[cyc]  = s_flush;
        for (int n = 0; n < NN; n++) begin
            h_req[cyc][n] = s_req[n];
            h_sel[cyc][n] = s_sel[n];
        end
        for (int b = 0; b < RN; b++) begin
            h_w[cyc][b]  = s_w[b];
            h_wq[cyc][b] = s_wq[b];
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) begin
            idle_stim();
            if (i < 6) begin
                s_rst = 1'b1;
                s_req = 4'($urandom);
            end
            tick();
            for (int n = 0; n < NN; n++) begin
                n_checks++;
                if (ntt_rdata_valid[n] !== exp_valid(cyc, n) || ntt_rdata_W[n] !== exp_data(cyc, n, 1'b0)
                    || ntt_rdata_WQ[n] !== exp_data(cyc, n, 1'b1)) begin
                    n_fail++;
                    $display("FAIL reset cyc=%0d ntt=%0d got v=%b W=%h WQ=%h exp v=%b W=%h WQ=%h", cyc, n,
                             ntt_rdata_valid[n], ntt_rdata_W[n], ntt_rdata_WQ[n], exp_valid(cyc, n),
                             exp_data(cyc, n, 1'b0), exp_data(cyc, n, 1'b1));
                end
            end
        end
    endtask

    task automatic test_single();
        int t0 = 0;
        twiddle_blk_t pat_w  = {4{16'h1234}};
        twiddle_blk_t pat_wq = {4{16'h5678}};
        for (int i = 0; i < 9; i++) begin
            idle_stim();
            if (i == 0) begin
                s_req    = 4'b0001;
                s_sel[0] = 2'd2;
            end
            if (i == DDLY) begin
                s_w[2]  = pat_w;
                s_wq[2] = pat_wq;
            end
            tick();
            if (i == 0) t0 = cyc;
            for (int n = 0; n < NN; n++) begin
                n_checks++;
                if (ntt_rdata_valid[n] !== exp_valid(cyc, n) || ntt_rdata_W[n] !== exp_data(cyc, n, 1'b0)
                    || ntt_rdata_WQ[n] !== exp_data(cyc, n, 1'b1)) begin
                    n_fail++;
                    $display("FAIL single cyc=%0d ntt=%0d got v=%b W=%h WQ=%h exp v=%b W=%h WQ=%h", cyc, n,
                             ntt_rdata_valid[n], ntt_rdata_W[n], ntt_rdata_WQ[n], exp_valid(cyc, n),
                             exp_data(cyc, n, 1'b0), exp_data(cyc, n, 1'b1));
                end
            end
            if (cyc == t0 + LAT) begin
                n_checks++;
                if (ntt_rdata_valid !== 4'b0001 || ntt_rdata_W[0] !== pat_w || ntt_rdata_WQ[0] !== pat_wq) begin
                    n_fail++;
                    $display("FAIL single_pattern got v=%b W=%h WQ=%h exp v=0001 W=%h WQ=%h",
                             ntt_rdata_valid, ntt_rdata_W[0], ntt_rdata_WQ[0], pat_w, pat_wq);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int seen = 0;
        for (int i = 0; i < 18; i++) begin
            idle_stim();
            if (i < 12) begin
                s_req    = 4'b0010;
                s_sel[1] = 2'(i % 4);
            end
            tick();
            if (ntt_rdata_valid[1] === 1'b1) seen++;
            for (int n = 0; n < NN; n++) begin
                n_checks++;
                if (ntt_rdata_valid[n] !== exp_valid(cyc, n) || ntt_rdata_W[n] !== exp_data(cyc, n, 1'b0)
                    || ntt_rdata_WQ[n] !== exp_data(cyc, n, 1'b1)) begin
                    n_fail++;
                    $display("FAIL back_to_back cyc=%0d ntt=%0d got v=%b W=%h WQ=%h exp v=%b W=%h WQ=%h", cyc, n,
                             ntt_rdata_valid[n], ntt_rdata_W[n], ntt_rdata_WQ[n], exp_valid(cyc, n),
                             exp_data(cyc, n, 1'b0), exp_data(cyc, n, 1'b1));
                end
            end
        end
        n_checks++;
        if (seen != 12) begin
            n_fail++;
            $display("FAIL back_to_back_count got %0d beats exp 12", seen);
        end
    endtask

    task automatic test_broadcast();
        for (int i = 0; i < 8; i++) begin
            idle_stim();
            if (i == 0) begin
                s_req = 4'b1111;
                s_sel = {4{2'd3}};
            end
            tick();
            for (int n = 0; n < NN; n++) begin
                n_checks++;
                if (ntt_rdata_valid[n] !== exp_valid(cyc, n) || ntt_rdata_W[n] !== exp_data(cyc, n, 1'b0)
                    || ntt_rdata_WQ[n] !== exp_data(cyc, n, 1'b1)) begin
                    n_fail++;
                    $display("FAIL broadcast cyc=%0d ntt=%0d got v=%b W=%h WQ=%h exp v=%b W=%h WQ=%h", cyc, n,
                             ntt_rdata_valid[n], ntt_rdata_W[n], ntt_rdata_WQ[n], exp_valid(cyc, n),
                             exp_data(cyc, n, 1'b0), exp_data(cyc, n, 1'b1));
                end
            end
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        for (int i = 0; i < 14; i++) begin
            idle_stim();
            if (i < 4) begin
                s_req = 4'b1111;
            end else if (i == 4) begin
                s_req   = 4'b0100;
                s_flush = 1'b1;
            end
            tick();
            if (i > 4) seen += int'($countones(ntt_rdata_valid));
            for (int n = 0; n < NN; n++) begin
                n_checks++;
                if (ntt_rdata_valid[n] !== exp_valid(cyc, n) || ntt_rdata_W[n] !== exp_data(cyc, n, 1'b0)
                    || ntt_rdata_WQ[n] !== exp_data(cyc, n, 1'b1)) begin
                    n_fail++;
                    $display("FAIL flush cyc=%0d ntt=%0d got v=%b W=%h WQ=%h exp v=%b W=%h WQ=%h", cyc, n,
                             ntt_rdata_valid[n], ntt_rdata_W[n], ntt_rdata_WQ[n], exp_valid(cyc, n),
                             exp_data(cyc, n, 1'b0), exp_data(cyc, n, 1'b1));
                end
            end
        end
        n_checks++;
        if (seen != 1) begin
            n_fail++;
            $display("FAIL flush_survivors got %0d beats exp 1", seen);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 24; i++) begin
            idle_stim();
            if (i < 16) s_req = 4'($urandom);
            if (i == 8) s_rst = 1'b1;
            tick();
            for (int n = 0; n < NN; n++) begin
                n_checks++;
                if (ntt_rdata_valid[n] !== exp_valid(cyc, n) || ntt_rdata_W[n] !== exp_data(cyc, n, 1'b0)
                    || ntt_rdata_WQ[n] !== exp_data(cyc, n, 1'b1)) begin
                    n_fail++;
                    $display("FAIL mid_reset cyc=%0d ntt=%0d got v=%b W=%h WQ=%h exp v=%b W=%h WQ=%h", cyc, n,
                             ntt_rdata_valid[n], ntt_rdata_W[n], ntt_rdata_WQ[n], exp_valid(cyc, n),
                             exp_data(cyc, n, 1'b0), exp_data(cyc, n, 1'b1));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            idle_stim();
            s_req   = 4'($urandom);
            s_flush = ($urandom_range(0, 15) == 0);
            s_rst   = ($urandom_range(0, 63) == 0);
            tick();
            for (int n = 0; n < NN; n++) begin
                n_checks++;
                if (ntt_rdata_valid[n] !== exp_valid(cyc, n) || ntt_rdata_W[n] !== exp_data(cyc, n, 1'b0)
                    || ntt_rdata_WQ[n] !== exp_data(cyc, n, 1'b1)) begin
                    n_fail++;
                    $display("FAIL random cyc=%0d ntt=%0d got v=%b W=%h WQ=%h exp v=%b W=%h WQ=%h", cyc, n,
                             ntt_rdata_valid[n], ntt_rdata_W[n], ntt_rdata_WQ[n], exp_valid(cyc, n),
                             exp_data(cyc, n, 1'b0), exp_data(cyc, n, 1'b1));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = '0; root_select = '0;
        root_rdata_W = '0; root_rdata_WQ = '0;
        idle_stim();
        test_reset();
        test_single();
        test_back_to_back();
        test_broadcast();
        test_flush();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
